// File: rtl/datapath_sequencer_pkg.sv
// Shared definitions for the multi-cycle R-type datapath sequencer.
package datapath_sequencer_pkg;

    localparam int INSTR_W  = 32;
    localparam int STATUS_W = 8;

    localparam logic [5:0] OPCODE_RTYPE = 6'b000000;

    // Sequencer phases; IDLE must stay the reset encoding.
    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_WB     = 3'd3,
        S_RESP   = 3'd4
    } seq_state_t;

    // True when the word carries the R-type opcode.
    function automatic logic is_rtype(input logic [INSTR_W-1:0] word);
        return word[31:26] == OPCODE_RTYPE;
    endfunction

endpackage

// File: rtl/datapath_sequencer.sv
// Multi-cycle controller for the single-cycle R-type datapath: accepts one
// machine-code word, holds it on the datapath while the ALU settles,
// captures the result, pulses the register-file write for one cycle and
// returns the captured result over a valid/ready handshake.
module datapath_sequencer
    import datapath_sequencer_pkg::*;
#(
    parameter int EXEC_CYCLES = 1,
    parameter int COUNT_W     = 16
) (
    input  logic                SYS_clk,
    input  logic                SYS_reset,
    input  logic                instr_valid,
    output logic                instr_ready,
    input  logic [31:0]         instr_in,
    output logic [31:0]         dp_machineCode,
    output logic                dp_reg_write,
    input  logic [31:0]         dp_alu_result,
    input  logic [7:0]          dp_alu_status,
    output logic                res_valid,
    input  logic                res_ready,
    output logic [31:0]         res_data,
    output logic [7:0]          res_status,
    output logic                res_illegal,
    output logic                busy,
    output logic [COUNT_W-1:0]  instr_count
);

    if (EXEC_CYCLES < 1 || EXEC_CYCLES > 15) begin : g_bad_exec_cycles
        $error("datapath_sequencer: EXEC_CYCLES must be in 1..15");
    end

    localparam logic [3:0] EXEC_LOAD = 4'(EXEC_CYCLES - 1);

    seq_state_t  state;
    logic [3:0]  exec_cnt;
    logic        illegal_q;

    // Handshake/status decode; the write enable is derived from state so an
    // asynchronous reset during WB drops it without waiting for a clock.
    assign instr_ready  = (state == S_IDLE);
    assign busy         = (state != S_IDLE);
    assign dp_reg_write = (state == S_WB) && !illegal_q;

    // Sequencer FSM with registered datapath word and response fields.
    always_ff @(posedge SYS_clk or posedge SYS_reset) begin
        if (SYS_reset) begin
            state          <= S_IDLE;
            dp_machineCode <= '0;
            illegal_q      <= 1'b0;
            exec_cnt       <= '0;
            res_valid      <= 1'b0;
            res_data       <= '0;
            res_status     <= '0;
            res_illegal    <= 1'b0;
            instr_count    <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (instr_valid) begin
                        dp_machineCode <= instr_in;
                        illegal_q      <= !is_rtype(instr_in);
                        state          <= S_DECODE;
                    end
                end
                S_DECODE: begin
                    exec_cnt <= EXEC_LOAD;
                    state    <= S_EXEC;
                end
                S_EXEC: begin
                    if (exec_cnt == 4'd0) begin
                        res_data   <= dp_alu_result;
                        res_status <= dp_alu_status;
                        state      <= S_WB;
                    end else begin
                        exec_cnt <= exec_cnt - 4'd1;
                    end
                end
                S_WB: begin
                    if (illegal_q) begin
                        res_data   <= '0;
                        res_status <= '0;
                    end else begin
                        instr_count <= instr_count + 1'b1;
                    end
                    res_illegal <= illegal_q;
                    res_valid   <= 1'b1;
                    state       <= S_RESP;
                end
                S_RESP: begin
                    if (res_ready) begin
                        res_valid <= 1'b0;
                        state     <= S_IDLE;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
